// File: rtl/watch_ctrl_pkg.sv
// Shared encodings for the watch/stopwatch mode controller.
package watch_ctrl_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'b00,
        RUN   = 2'b01,
        CLEAR = 2'b10
    } sw_state_t;

    localparam int FLD_MSEC = 0;
    localparam int FLD_SEC  = 1;
    localparam int FLD_MIN  = 2;
    localparam int FLD_HOUR = 3;

    // Bit positions of the buttons in the edge-detector vector; lower index = higher priority.
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_LEFT  = 3;
    localparam int NUM_BTNS  = 4;

endpackage

// File: rtl/btn_edge_detect.sv
// Registers debounced button levels and emits one-cycle rise pulses.
module btn_edge_detect #(
    parameter int NUM_BTNS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] levels,
    output logic [NUM_BTNS-1:0] rises
);

    logic [NUM_BTNS-1:0] levels_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            levels_reg <= '0;
        end else begin
            levels_reg <= levels;
        end
    end

    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_rise
        assign rises[gi] = levels[gi] & ~levels_reg[gi];
    end

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch/stopwatch mode controller: stopwatch run/clear FSM plus field edit with inactivity timeout.
// Optional hold-to-repeat on up/down is enabled by defining WATCH_MODE_CTRL_AUTOREPEAT_EN.
module watch_mode_ctrl
    import watch_ctrl_pkg::*;
#(
    parameter  int NUM_FIELDS   = 4,
    parameter  int EDIT_TIMEOUT = 10000,
    parameter  int REPEAT_DELAY = 500,
    parameter  int REPEAT_RATE  = 100,
    localparam int FIELD_W      = $clog2(NUM_FIELDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_tick,
    input  logic                  i_up,
    input  logic                  i_down,
    input  logic                  i_right,
    input  logic                  i_left,
    input  logic                  i_watch_select,
    input  logic                  i_edit,
    output logic                  o_run_stop,
    output logic                  o_clear,
    output logic [FIELD_W-1:0]    o_field_sel,
    output logic                  o_inc,
    output logic                  o_dec,
    output logic                  o_edit_active,
    output logic [NUM_FIELDS-1:0] LED
);

    localparam int TMO_W = (EDIT_TIMEOUT < 2) ? 1 : $clog2(EDIT_TIMEOUT);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(EDIT_TIMEOUT - 1);
    localparam logic [FIELD_W-1:0] FIELD_MAX = FIELD_W'(NUM_FIELDS - 1);
    localparam logic [FIELD_W-1:0] FIELD_RST = FIELD_W'(FLD_MSEC);

    logic [NUM_BTNS-1:0] levels;
    logic [NUM_BTNS-1:0] rises;
    logic [NUM_BTNS-1:0] evt;

    sw_state_t           sw_reg, sw_next;
    logic [FIELD_W-1:0]  field_reg, field_next;
    logic [TMO_W-1:0]    tmo_reg, tmo_next;
    logic                edit_prev_reg;
    logic                edit_raw;
    logic                edit_entry;
    logic                rep_pulse;
    logic                rep_inc;
    logic                rep_dec;

    assign levels = {i_left, i_right, i_down, i_up};

    btn_edge_detect #(
        .NUM_BTNS(NUM_BTNS)
    ) u_edges (
        .clk    (clk),
        .reset  (reset),
        .levels (levels),
        .rises  (rises)
    );

    // Keep only the highest-priority rising edge of this cycle.
    always_comb begin
        evt            = '0;
        evt[BTN_UP]    = rises[BTN_UP];
        evt[BTN_DOWN]  = rises[BTN_DOWN]  & ~rises[BTN_UP];
        evt[BTN_RIGHT] = rises[BTN_RIGHT] & ~rises[BTN_UP] & ~rises[BTN_DOWN];
        evt[BTN_LEFT]  = rises[BTN_LEFT]  & ~rises[BTN_UP] & ~rises[BTN_DOWN] & ~rises[BTN_RIGHT];
    end

    assign edit_raw   = i_edit & ~i_watch_select;
    assign edit_entry = edit_raw & ~edit_prev_reg;

    always_comb begin
        sw_next = sw_reg;
        case (sw_reg)
            STOP: begin
                if (i_watch_select && evt[BTN_RIGHT]) begin
                    sw_next = RUN;
                end else if (i_watch_select && evt[BTN_LEFT]) begin
                    sw_next = CLEAR;
                end
            end
            RUN: begin
                if (i_watch_select && evt[BTN_RIGHT]) begin
                    sw_next = STOP;
                end
            end
            CLEAR:   sw_next = STOP;
            default: sw_next = STOP;
        endcase
    end

`ifdef WATCH_MODE_CTRL_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = (REP_MAX < 2) ? 1 : $clog2(REP_MAX);
    localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    logic             rep_act_reg, rep_act_next;
    logic             rep_dir_reg, rep_dir_next;
    logic             rep_first_reg, rep_first_next;
    logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
    logic [REP_W-1:0] rep_limit;
    logic             rep_held;

    // rep_dir_reg: 0 = up is repeating, 1 = down is repeating.
    assign rep_held  = rep_dir_reg ? i_down : i_up;
    assign rep_limit = rep_first_reg ? REP_DELAY_LAST : REP_RATE_LAST;

    always_comb begin
        rep_act_next   = rep_act_reg;
        rep_dir_next   = rep_dir_reg;
        rep_first_next = rep_first_reg;
        rep_cnt_next   = rep_cnt_reg;
        rep_pulse      = 1'b0;
        if (!edit_raw) begin
            rep_act_next = 1'b0;
            rep_cnt_next = '0;
        end else if (evt[BTN_UP] || evt[BTN_DOWN]) begin
            rep_act_next   = 1'b1;
            rep_dir_next   = evt[BTN_DOWN];
            rep_first_next = 1'b1;
            rep_cnt_next   = '0;
        end else if (!rep_act_reg || !rep_held) begin
            rep_act_next = 1'b0;
            rep_cnt_next = '0;
        end else if (i_tick) begin
            if (rep_cnt_reg == rep_limit) begin
                rep_pulse      = ~|evt;
                rep_first_next = 1'b0;
                rep_cnt_next   = '0;
            end else begin
                rep_cnt_next = rep_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_act_reg   <= 1'b0;
            rep_dir_reg   <= 1'b0;
            rep_first_reg <= 1'b0;
            rep_cnt_reg   <= '0;
        end else begin
            rep_act_reg   <= rep_act_next;
            rep_dir_reg   <= rep_dir_next;
            rep_first_reg <= rep_first_next;
            rep_cnt_reg   <= rep_cnt_next;
        end
    end

    assign rep_inc = rep_pulse & ~rep_dir_reg;
    assign rep_dec = rep_pulse &  rep_dir_reg;
`else
    assign rep_pulse = 1'b0;
    assign rep_inc   = 1'b0;
    assign rep_dec   = 1'b0;
`endif

    // A button event or repeat pulse in the timeout cycle wins over the timeout.
    always_comb begin
        field_next = field_reg;
        tmo_next   = tmo_reg;
        if (!edit_raw) begin
            tmo_next = '0;
        end else if (edit_entry) begin
            field_next = FIELD_RST;
            tmo_next   = '0;
        end else if ((|evt) || rep_pulse) begin
            tmo_next = '0;
            if (evt[BTN_LEFT]) begin
                field_next = (field_reg == FIELD_MAX) ? '0 : field_reg + 1'b1;
            end else if (evt[BTN_RIGHT]) begin
                field_next = (field_reg == '0) ? FIELD_MAX : field_reg - 1'b1;
            end
        end else if (i_tick) begin
            if (tmo_reg == TMO_LAST) begin
                field_next = FIELD_RST;
                tmo_next   = '0;
            end else begin
                tmo_next = tmo_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_reg        <= STOP;
            field_reg     <= FIELD_RST;
            tmo_reg       <= '0;
            edit_prev_reg <= 1'b0;
        end else begin
            sw_reg        <= sw_next;
            field_reg     <= field_next;
            tmo_reg       <= tmo_next;
            edit_prev_reg <= edit_raw;
        end
    end

    assign o_run_stop    = (sw_reg == RUN);
    assign o_clear       = (sw_reg == CLEAR);
    assign o_field_sel   = field_reg;
    assign o_edit_active = edit_raw & ~reset;
    assign o_inc         = ~reset & ((edit_raw & evt[BTN_UP])   | rep_inc);
    assign o_dec         = ~reset & ((edit_raw & evt[BTN_DOWN]) | rep_dec);

    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_led
        assign LED[gi] = o_edit_active & (field_reg == FIELD_W'(gi));
    end

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Directed bench for watch_mode_ctrl (NUM_FIELDS=6, EDIT_TIMEOUT=20, REPEAT_DELAY=5, REPEAT_RATE=2).
// Repeat expectations follow WATCH_MODE_CTRL_AUTOREPEAT_EN when it is defined.
module tb_watch_mode_ctrl;

    logic       clk;
    logic       reset;
    logic       i_tick;
    logic       i_up, i_down, i_right, i_left;
    logic       i_watch_select;
    logic       i_edit;
    logic       o_run_stop;
    logic       o_clear;
    logic [2:0] o_field_sel;
    logic       o_inc;
    logic       o_dec;
    logic       o_edit_active;
    logic [5:0] LED;

    int n_checks = 0;
    int n_fail   = 0;

    watch_mode_ctrl #(
        .NUM_FIELDS   (6),
        .EDIT_TIMEOUT (20),
        .REPEAT_DELAY (5),
        .REPEAT_RATE  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_tick         (i_tick),
        .i_up           (i_up),
        .i_down         (i_down),
        .i_right        (i_right),
        .i_left         (i_left),
        .i_watch_select (i_watch_select),
        .i_edit         (i_edit),
        .o_run_stop     (o_run_stop),
        .o_clear        (o_clear),
        .o_field_sel    (o_field_sel),
        .o_inc          (o_inc),
        .o_dec          (o_dec),
        .o_edit_active  (o_edit_active),
        .LED            (LED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after a rising edge; checks happen 1 ns after that.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_left();
        i_left = 1'b1; cyc(1); i_left = 1'b0; cyc(1);
    endtask

    task automatic press_right();
        i_right = 1'b1; cyc(1); i_right = 1'b0; cyc(1);
    endtask

    task automatic idle_ticks(input int n);
        repeat (n) begin
            i_tick = 1'b1; cyc(1); i_tick = 1'b0; cyc(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; i_tick = 0; i_up = 0; i_down = 0; i_right = 0; i_left = 0;
        i_watch_select = 0; i_edit = 0;
        cyc(3);
        n_checks++; if (o_run_stop !== 1'b0) begin n_fail++; $display("FAIL reset_run_stop got=%b exp=0", o_run_stop); end
        n_checks++; if (o_clear !== 1'b0) begin n_fail++; $display("FAIL reset_clear got=%b exp=0", o_clear); end
        n_checks++; if (o_field_sel !== 3'd0) begin n_fail++; $display("FAIL reset_field got=%0d exp=0", o_field_sel); end
        i_edit = 1; i_up = 1; #1;
        n_checks++; if (o_inc !== 1'b0) begin n_fail++; $display("FAIL reset_inc_gated got=%b exp=0", o_inc); end
        n_checks++; if (o_edit_active !== 1'b0) begin n_fail++; $display("FAIL reset_edit_active got=%b exp=0", o_edit_active); end
        n_checks++; if (LED !== 6'b0) begin n_fail++; $display("FAIL reset_led got=%b exp=000000", LED); end
        i_edit = 0; i_up = 0;
        cyc(1);
        reset = 1'b0;
        cyc(2);
        $display("reset done: run=%b field=%0d", o_run_stop, o_field_sel);
    endtask

    task automatic test_stopwatch();
        i_watch_select = 1;
        i_right = 1; #1;
        n_checks++; if (o_run_stop !== 1'b0) begin n_fail++; $display("FAIL sw_run_same_cycle got=%b exp=0", o_run_stop); end
        cyc(1);
        n_checks++; if (o_run_stop !== 1'b1) begin n_fail++; $display("FAIL sw_start got=%b exp=1", o_run_stop); end
        i_right = 0; cyc(1);
        press_right();
        n_checks++; if (o_run_stop !== 1'b0) begin n_fail++; $display("FAIL sw_stop got=%b exp=0", o_run_stop); end
        i_left = 1; cyc(1);
        n_checks++; if (o_clear !== 1'b1) begin n_fail++; $display("FAIL sw_clear_pulse got=%b exp=1", o_clear); end
        n_checks++; if (o_run_stop !== 1'b0) begin n_fail++; $display("FAIL sw_clear_run got=%b exp=0", o_run_stop); end
        i_left = 0; cyc(1);
        n_checks++; if (o_clear !== 1'b0) begin n_fail++; $display("FAIL sw_clear_width got=%b exp=0", o_clear); end
        cyc(1);
        n_checks++; if (o_clear !== 1'b0 || o_run_stop !== 1'b0) begin n_fail++; $display("FAIL sw_after_clear got=%b%b exp=00", o_clear, o_run_stop); end
        $display("stopwatch start/stop/clear done");
    endtask

    task automatic test_background();
        i_watch_select = 1;
        press_right();
        i_watch_select = 0; cyc(1);
        press_right();
        n_checks++; if (o_run_stop !== 1'b1) begin n_fail++; $display("FAIL bg_run_kept got=%b exp=1", o_run_stop); end
        i_watch_select = 1; cyc(1);
        i_left = 1; cyc(1);
        n_checks++; if (o_clear !== 1'b0) begin n_fail++; $display("FAIL bg_left_in_run got=%b exp=0", o_clear); end
        i_left = 0; cyc(1);
        n_checks++; if (o_clear !== 1'b0 || o_run_stop !== 1'b1) begin n_fail++; $display("FAIL bg_still_run got=%b%b exp=01", o_clear, o_run_stop); end
        press_right();
        n_checks++; if (o_run_stop !== 1'b0) begin n_fail++; $display("FAIL bg_stop got=%b exp=0", o_run_stop); end
        $display("background run done");
    endtask

    task automatic test_field_wrap();
        i_watch_select = 0; i_edit = 1; #1;
        n_checks++; if (o_edit_active !== 1'b1) begin n_fail++; $display("FAIL edit_active got=%b exp=1", o_edit_active); end
        cyc(1);
        n_checks++; if (o_field_sel !== 3'd0 || LED !== 6'b000001) begin n_fail++; $display("FAIL edit_entry got=%0d/%b exp=0/000001", o_field_sel, LED); end
        press_right();
        n_checks++; if (o_field_sel !== 3'd5 || LED !== 6'b100000) begin n_fail++; $display("FAIL wrap_down got=%0d/%b exp=5/100000", o_field_sel, LED); end
        press_left();
        n_checks++; if (o_field_sel !== 3'd0) begin n_fail++; $display("FAIL wrap_up got=%0d exp=0", o_field_sel); end
        press_left();
        n_checks++; if (o_field_sel !== 3'd1 || LED !== 6'b000010) begin n_fail++; $display("FAIL field_one got=%0d/%b exp=1/000010", o_field_sel, LED); end
        i_edit = 0; cyc(1);
        n_checks++; if (o_field_sel !== 3'd1 || LED !== 6'b0 || o_edit_active !== 1'b0) begin n_fail++; $display("FAIL edit_off_hold got=%0d/%b/%b exp=1/000000/0", o_field_sel, LED, o_edit_active); end
        i_up = 1; #1;
        n_checks++; if (o_inc !== 1'b0) begin n_fail++; $display("FAIL inc_not_editing got=%b exp=0", o_inc); end
        cyc(1); i_up = 0; cyc(1);
        i_edit = 1; cyc(1);
        n_checks++; if (o_field_sel !== 3'd0) begin n_fail++; $display("FAIL reentry_zero got=%0d exp=0", o_field_sel); end
        $display("field wrap done: field=%0d", o_field_sel);
    endtask

    task automatic test_simultaneous();
        press_left(); press_left();
        i_up = 1; i_left = 1; #1;
        n_checks++; if (o_inc !== 1'b1) begin n_fail++; $display("FAIL simul_inc got=%b exp=1", o_inc); end
        cyc(1);
        n_checks++; if (o_field_sel !== 3'd2 || o_inc !== 1'b0) begin n_fail++; $display("FAIL simul_field got=%0d/%b exp=2/0", o_field_sel, o_inc); end
        i_up = 0; i_left = 0; cyc(1);
        i_down = 1; i_right = 1; #1;
        n_checks++; if (o_dec !== 1'b1 || o_inc !== 1'b0) begin n_fail++; $display("FAIL simul_dec got=%b%b exp=10", o_dec, o_inc); end
        cyc(1);
        n_checks++; if (o_field_sel !== 3'd2) begin n_fail++; $display("FAIL simul_field2 got=%0d exp=2", o_field_sel); end
        i_down = 0; i_right = 0; cyc(1);
        $display("simultaneous edges done");
    endtask

    task automatic test_timeout();
        press_left();
        idle_ticks(19);
        n_checks++; if (o_field_sel !== 3'd3) begin n_fail++; $display("FAIL tmo_before got=%0d exp=3", o_field_sel); end
        idle_ticks(1);
        n_checks++; if (o_field_sel !== 3'd0) begin n_fail++; $display("FAIL tmo_fire got=%0d exp=0", o_field_sel); end
        press_left(); press_left(); press_left();
        idle_ticks(19);
        i_tick = 1; i_left = 1; cyc(1); i_tick = 0; i_left = 0; cyc(1);
        n_checks++; if (o_field_sel !== 3'd4) begin n_fail++; $display("FAIL tmo_event_wins got=%0d exp=4", o_field_sel); end
        idle_ticks(19);
        n_checks++; if (o_field_sel !== 3'd4) begin n_fail++; $display("FAIL tmo_cleared got=%0d exp=4", o_field_sel); end
        idle_ticks(1);
        n_checks++; if (o_field_sel !== 3'd0) begin n_fail++; $display("FAIL tmo_second got=%0d exp=0", o_field_sel); end
        $display("timeout done");
    endtask

    task automatic test_autorepeat();
        logic exp_inc;
        press_left(); press_left();
        i_up = 1; #1;
        n_checks++; if (o_inc !== 1'b1) begin n_fail++; $display("FAIL rep_press got=%b exp=1", o_inc); end
        for (int k = 1; k <= 11; k++) begin
            cyc(1);
            n_checks++; if (o_inc !== 1'b0) begin n_fail++; $display("FAIL rep_gap%0d got=%b exp=0", k, o_inc); end
            i_tick = 1; #1;
`ifdef WATCH_MODE_CTRL_AUTOREPEAT_EN
            exp_inc = (k == 5 || k == 7 || k == 9 || k == 11);
`else
            exp_inc = 1'b0;
`endif
            n_checks++; if (o_inc !== exp_inc) begin n_fail++; $display("FAIL rep_tick%0d got=%b exp=%b", k, o_inc, exp_inc); end
            cyc(1); i_tick = 0;
            $display("hold tick %0d: inc=%b", k, exp_inc);
        end
        n_checks++; if (o_field_sel !== 3'd2) begin n_fail++; $display("FAIL rep_field got=%0d exp=2", o_field_sel); end
        reset = 1; i_tick = 1; #1;
        n_checks++; if (o_inc !== 1'b0) begin n_fail++; $display("FAIL rep_reset_pulse got=%b exp=0", o_inc); end
        cyc(1); i_tick = 0;
        n_checks++; if (o_field_sel !== 3'd0 || o_inc !== 1'b0) begin n_fail++; $display("FAIL rep_reset_state got=%0d/%b exp=0/0", o_field_sel, o_inc); end
        i_up = 0; cyc(1);
        reset = 0; cyc(1);
        for (int k = 0; k < 6; k++) begin
            i_tick = 1; #1;
            n_checks++; if (o_inc !== 1'b0) begin n_fail++; $display("FAIL rep_after_reset%0d got=%b exp=0", k, o_inc); end
            cyc(1); i_tick = 0; cyc(1);
        end
        n_checks++; if (o_field_sel !== 3'd0 || o_run_stop !== 1'b0) begin n_fail++; $display("FAIL post_reset got=%0d/%b exp=0/0", o_field_sel, o_run_stop); end
        $display("autorepeat/reset-mid-hold done");
    endtask

    initial begin
        test_reset();
        test_stopwatch();
        test_background();
        test_field_wrap();
        test_simultaneous();
        test_timeout();
        test_autorepeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/watch_mode_ctrl.md
Name: watch_mode_ctrl

Overview:
Parametrised successor to the watch/stopwatch control FSM. It turns debounced button levels and mode switches into stopwatch run/clear controls and per-field edit commands. The number of editable fields is generic, and an edit inactivity timeout is added. The block sits between the button debouncers and the watch/stopwatch datapaths.

Parameters:
NUM_FIELDS, 4, number of editable watch fields (index 0 = msec … NUM_FIELDS-1 = hour); must be ≥2
EDIT_TIMEOUT, 10000, i_tick periods without a button press before the edit field returns to index 0
REPEAT_DELAY, 500, i_tick periods an up/down button must be held before auto-repeat starts (optional feature)
REPEAT_RATE, 100, i_tick periods between auto-repeat pulses (optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_tick  in  1  1 ms strobe, one clk wide
i_up  in  1  debounced button level
i_down  in  1  debounced button level
i_right  in  1  debounced level; run/stop in stopwatch mode, field-down in edit mode
i_left  in  1  debounced level; clear in stopwatch mode, field-up in edit mode
i_watch_select  in  1  0 = watch, 1 = stopwatch
i_edit  in  1  1 = watch edit enabled (ignored while i_watch_select=1)
o_run_stop  out  1  stopwatch running
o_clear  out  1  one-cycle stopwatch clear pulse
o_field_sel  out  FIELD_W  active edit field; FIELD_W = $clog2(NUM_FIELDS)
o_inc  out  1  one-cycle increment pulse for o_field_sel
o_dec  out  1  one-cycle decrement pulse for o_field_sel
o_edit_active  out  1  1 when i_edit=1 and i_watch_select=0
LED  out  NUM_FIELDS  one-hot of o_field_sel when editing, else 0

Behaviour:
- Reset (synchronous): stopwatch state STOP, field index 0, timeout counter 0, edge registers 0. All outputs 0 except o_field_sel=0.
- Button events are rising edges of the level inputs, using a one-register edge detector. A command takes effect in the same cycle it is detected (Mealy pulses); state updates on the next edge.
- Simultaneous edges: priority is up > down > right > left. Only one event is acted on per cycle; the rest are discarded.
- Stopwatch FSM (STOP, RUN, CLEAR) acts on events only when i_watch_select=1.
  - STOP: right → RUN; left → CLEAR.
  - RUN: right → STOP; left is ignored.
  - CLEAR: o_clear=1 for exactly one cycle, then STOP unconditionally.
  - o_run_stop=1 only in RUN.
  - The stopwatch keeps running while watch mode is selected: o_run_stop is not gated by i_watch_select.
- Edit logic is active only when o_edit_active=1.
  - up → o_inc=1 for one cycle; down → o_dec=1 for one cycle.
  - left → index+1, wrapping NUM_FIELDS-1 → 0.
  - right → index-1, wrapping 0 → NUM_FIELDS-1.
- A rising edge of o_edit_active forces the index to 0 and clears the timeout counter.
- When o_edit_active=0: o_inc=o_dec=0 and LED=0. The index holds its value.
- Timeout: the counter increments on each i_tick while editing and clears on any accepted event. When it reaches EDIT_TIMEOUT, the index goes to 0 and the counter clears. An event in the same cycle as the timeout wins: the event is applied and the counter clears.
- Reset asserted mid-RUN or mid-edit returns everything to the reset state on the next clock edge. No pulses are emitted on that edge.

Optional Feature:
WATCH_MODE_CTRL_AUTOREPEAT_EN
- Defined: while up (or down) stays held in edit mode, count i_tick periods. After REPEAT_DELAY ticks emit o_inc (o_dec), then emit one every REPEAT_RATE ticks until release.
  - Each repeat pulse clears the timeout counter.
  - Releasing the button, or pressing the other one, resets the repeat counter.
- Undefined: no repeat counter exists; only edges generate pulses.

Decomposition:
- Package watch_ctrl_pkg holds:
  - stopwatch state encodings STOP=2'b00, RUN=2'b01, CLEAR=2'b10;
  - field index constants FLD_MSEC=0, FLD_SEC=1, FLD_MIN=2, FLD_HOUR=3.
- One sub-module, btn_edge_detect, parametrised by button count (4). It registers the levels and outputs one-cycle rise pulses.

Test Plan:
1. Stopwatch start/stop/clear: sw=1, pulse right → o_run_stop=1 next cycle; right again → 0; left → o_clear=1 for exactly 1 cycle, o_run_stop stays 0.
2. Background run: RUN, then sw=0 and press right → o_run_stop stays 1; left while RUN with sw=1 → no o_clear.
3. Field wrap with NUM_FIELDS=6: enter edit → o_field_sel=0, LED=6'b000001; right → 5; left ×2 → 1, LED=6'b000010.
4. Simultaneous up+left edges at field 2 → o_inc=1, o_field_sel stays 2.
5. Timeout with EDIT_TIMEOUT=20: field 3, idle 20 ticks → o_field_sel=0; a press on tick 20 → its event applied, counter cleared.
6. With the macro defined, REPEAT_DELAY=5, REPEAT_RATE=2: hold up 11 ticks → o_inc pulses at press, tick 5, 7, 9, 11; reset mid-hold → no pulses, index 0.
